// File: rtl/rv_pkg.sv
// Shared RISC-V front-end definitions: NOP word, opcode constants, fetch-stage
// state encoding and the instruction-buffer entry layout.
// Optional macro IF_PREDECODE_EN adds three predecode flags to each buffer entry.
package rv_pkg;

    localparam int unsigned PC_W   = 30;
    localparam int unsigned INST_W = 32;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_RUN  = 2'd1,
        IF_HALT = 2'd2
    } if_state_e;

    // One buffered fetch result
    typedef struct packed {
`ifdef IF_PREDECODE_EN
        logic              pd_jal;
        logic              pd_branch;
        logic              pd_system;
`endif
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } if_entry_t;

    // {jal, branch, system} flags from the major opcode
    function automatic logic [2:0] predecode(input logic [6:0] opc);
        return {opc == OPC_JAL, opc == OPC_BRANCH, opc == OPC_SYSTEM};
    endfunction

endpackage

// File: rtl/if_inst_fifo.sv
// Synchronous FIFO holding fetched instructions until decode accepts them.
// Ports: clk, rst_n (async active-low); i_clear empties the FIFO (wins over
// push/pop); i_push/i_wdata write; i_pop reads; o_rdata is the head entry,
// readable in the same cycle; o_count/o_full/o_empty report occupancy.
// DEPTH must be a power of two so the pointers wrap naturally.
module if_inst_fifo #(
    parameter int unsigned DATA_W = 62,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic [DATA_W-1:0]      i_wdata,
    input  logic                   i_pop,
    output logic [DATA_W-1:0]      o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_do_push = i_push & ~i_clear;
    assign w_do_pop  = i_pop & ~o_empty & ~i_clear;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues reads for the PC-stage word address to a
// fixed-latency instruction memory, tags each read with a 1-bit epoch, buffers
// returned words and presents {inst, pc} to decode.
// Ports: clk, rst_n (async active-low); cpu_start/cpu_stop control;
// pc in / fetch_adv out to the PC stage; redirect flushes; stall from decode;
// imem_re/imem_adr/imem_rdata memory interface; inst_id/pc_id/inst_vld_id to
// decode; if_busy while reads are in flight or the buffer holds data.
// Macro IF_PREDECODE_EN adds pd_jal_id/pd_branch_id/pd_system_id outputs.
module if_stage #(
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned BUF_DEPTH = 2,
    parameter logic [31:0] NOP_INST  = rv_pkg::NOP_INST
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_start,
    input  logic                     cpu_stop,
    input  logic [rv_pkg::PC_W-1:0]  pc,
    output logic                     fetch_adv,
    input  logic                     redirect,
    input  logic                     stall,
    output logic                     imem_re,
    output logic [rv_pkg::PC_W-1:0]  imem_adr,
    input  logic [rv_pkg::INST_W-1:0] imem_rdata,
    output logic [rv_pkg::INST_W-1:0] inst_id,
    output logic [rv_pkg::PC_W-1:0]  pc_id,
    output logic                     inst_vld_id,
    output logic                     if_busy
`ifdef IF_PREDECODE_EN
    ,
    output logic                     pd_jal_id,
    output logic                     pd_branch_id,
    output logic                     pd_system_id
`endif
);

    localparam int unsigned PC_W   = rv_pkg::PC_W;
    localparam int unsigned CNT_W  = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned SUM_W  = $clog2(RD_LAT + BUF_DEPTH + 1);
    localparam int unsigned DATA_W = $bits(rv_pkg::if_entry_t);

    rv_pkg::if_state_e r_state;
    rv_pkg::if_state_e w_state_nxt;

    logic              r_epoch;
    logic [PC_W-1:0]   r_pc_last;

    logic              r_tag_vld [RD_LAT];
    logic [PC_W-1:0]   r_tag_pc  [RD_LAT];
    logic              r_tag_ep  [RD_LAT];

    logic              w_flush;
    logic              w_issue;
    logic [SUM_W-1:0]  w_inflight;
    logic              w_push;
    logic              w_pop;
    logic              w_vld;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    rv_pkg::if_entry_t w_wentry;
    rv_pkg::if_entry_t w_rentry;

    // Redirect and start both kill everything fetched under the old epoch
    assign w_flush = redirect | cpu_start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= rv_pkg::IF_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: start wins over stop
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            rv_pkg::IF_IDLE: w_state_nxt = rv_pkg::IF_IDLE;
            rv_pkg::IF_RUN:  if (cpu_stop) w_state_nxt = rv_pkg::IF_HALT;
            rv_pkg::IF_HALT: w_state_nxt = rv_pkg::IF_HALT;
            default:         w_state_nxt = rv_pkg::IF_IDLE;
        endcase
        if (cpu_start) w_state_nxt = rv_pkg::IF_RUN;
    end

    // Reads currently travelling through the memory pipeline
    always_comb begin
        w_inflight = '0;
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            w_inflight = w_inflight + SUM_W'(r_tag_vld[i]);
        end
    end

    // Credit uses registered occupancy only; a same-cycle pop never adds credit
    always_comb begin
        w_issue = 1'b0;
        if ((r_state == rv_pkg::IF_RUN) && !w_flush && !cpu_stop &&
            ((w_inflight + SUM_W'(w_count)) < SUM_W'(BUF_DEPTH))) begin
            w_issue = 1'b1;
        end
    end

    assign imem_re   = w_issue;
    assign fetch_adv = w_issue;
    assign imem_adr  = pc;

    // Epoch flips on every flush so stale returns are recognised at the tail
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_epoch <= 1'b0;
        else if (w_flush) r_epoch <= ~r_epoch;
    end

    // Tag pipeline aligned with memory latency. Valids behind stage 0 are also
    // dropped on flush so back-to-back flushes cannot alias the 1-bit epoch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                r_tag_vld[i] <= 1'b0;
                r_tag_pc[i]  <= '0;
                r_tag_ep[i]  <= 1'b0;
            end
        end else begin
            r_tag_vld[0] <= w_issue;
            r_tag_pc[0]  <= pc;
            r_tag_ep[0]  <= r_epoch;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1] & ~w_flush;
                r_tag_pc[i]  <= r_tag_pc[i-1];
                r_tag_ep[i]  <= r_tag_ep[i-1];
            end
        end
    end

    // Accept returning data only if it belongs to the current epoch
    assign w_push = r_tag_vld[RD_LAT-1] & (r_tag_ep[RD_LAT-1] == r_epoch) & ~w_flush;

    always_comb begin
        w_wentry      = '0;
        w_wentry.inst = imem_rdata;
        w_wentry.pc   = r_tag_pc[RD_LAT-1];
`ifdef IF_PREDECODE_EN
        {w_wentry.pd_jal, w_wentry.pd_branch, w_wentry.pd_system} =
            rv_pkg::predecode(imem_rdata[6:0]);
`endif
    end

    assign w_vld = ~w_empty & ~w_flush;
    assign w_pop = w_vld & ~stall;

    if_inst_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_flush),
        .i_push  (w_push),
        .i_wdata (w_wentry),
        .i_pop   (w_pop),
        .o_rdata (w_rentry),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // pc_id keeps showing the last head once the buffer runs dry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_pc_last <= '0;
        else if (!w_empty) r_pc_last <= w_rentry.pc;
    end

    // Decode-facing outputs
    always_comb begin
        inst_vld_id = w_vld;
        inst_id     = w_vld ? w_rentry.inst : NOP_INST;
        pc_id       = w_empty ? r_pc_last : w_rentry.pc;
        if_busy     = (w_inflight != '0) | ~w_empty;
`ifdef IF_PREDECODE_EN
        pd_jal_id    = w_vld & w_rentry.pd_jal;
        pd_branch_id = w_vld & w_rentry.pd_branch;
        pd_system_id = w_vld & w_rentry.pd_system;
`endif
    end

    // Credit accounting must make a push into a full buffer impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && w_full));

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage (RD_LAT=2, BUF_DEPTH=2): fetch, backpressure,
// halt/drain, redirect, redirect+stall+push, and reset while full.
module tb_if_stage;

    localparam int unsigned RD_LAT    = 2;
    localparam int unsigned BUF_DEPTH = 2;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        cpu_start;
    logic        cpu_stop;
    logic [29:0] pc_r;
    logic        fetch_adv;
    logic        redirect;
    logic        stall;
    logic        imem_re;
    logic [29:0] imem_adr;
    logic [31:0] imem_rdata;
    logic [31:0] inst_id;
    logic [29:0] pc_id;
    logic        inst_vld_id;
    logic        if_busy;
`ifdef IF_PREDECODE_EN
    logic        pd_jal_id;
    logic        pd_branch_id;
    logic        pd_system_id;
`endif

    int          n_vec;
    int          n_err;
    int          nissue;
    int          npop;
    int          max_out;
    logic [29:0] exp_pc;
    logic [29:0] load_val;
    bit          load_pend;
    bit          hist0;
    bit          hist1;

    if_stage #(
        .RD_LAT    (RD_LAT),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_start   (cpu_start),
        .cpu_stop    (cpu_stop),
        .pc          (pc_r),
        .fetch_adv   (fetch_adv),
        .redirect    (redirect),
        .stall       (stall),
        .imem_re     (imem_re),
        .imem_adr    (imem_adr),
        .imem_rdata  (imem_rdata),
        .inst_id     (inst_id),
        .pc_id       (pc_id),
        .inst_vld_id (inst_vld_id),
        .if_busy     (if_busy)
`ifdef IF_PREDECODE_EN
        ,
        .pd_jal_id    (pd_jal_id),
        .pd_branch_id (pd_branch_id),
        .pd_system_id (pd_system_id)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory content is derived from the word address
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {2'b10, a};
    endfunction

    // Synchronous memory with RD_LAT-cycle read latency
    logic [31:0] r_mp [RD_LAT];
    always @(posedge clk) begin
        r_mp[0] <= mem_word(imem_adr);
        for (int k = 1; k < RD_LAT; k++) r_mp[k] <= r_mp[k-1];
    end
    assign imem_rdata = r_mp[RD_LAT-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic settle();
        #2;
    endtask

    // One clock: sample at negedge (pops checked in order), then PC-stage model
    task automatic tick();
        logic adv;
        @(negedge clk);
        adv = fetch_adv;
        if (inst_vld_id && !stall) begin
            chk("pop_pc", 32'(pc_id), 32'(exp_pc));
            chk("pop_inst", inst_id, mem_word(exp_pc));
            exp_pc = exp_pc + 30'd1;
            npop++;
        end
        if (adv) nissue++;
        @(posedge clk);
        #1;
        if (nissue - npop > max_out) max_out = nissue - npop;
        hist1 = hist0;
        hist0 = adv;
        if (load_pend) begin
            pc_r      = load_val;
            load_pend = 1'b0;
        end else if (adv) begin
            pc_r = pc_r + 30'd1;
        end
    endtask

    task automatic run_until(input int target, input int bound, input string tag);
        int n;
        n = 0;
        while (npop < target && n < bound) begin
            tick();
            n++;
        end
        chk(tag, 32'(npop), 32'(target));
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_re"},   32'(imem_re),     32'd0);
        chk({pfx, "_adv"},  32'(fetch_adv),   32'd0);
        chk({pfx, "_vld"},  32'(inst_vld_id), 32'd0);
        chk({pfx, "_inst"}, inst_id,          NOP);
        chk({pfx, "_pc"},   32'(pc_id),       32'd0);
        chk({pfx, "_busy"}, 32'(if_busy),     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  iss0;
        int  base;
        int  n;
        int  out_now;
        bit  found;

        n_vec = 0; n_err = 0; nissue = 0; npop = 0; max_out = 0;
        hist0 = 0; hist1 = 0; load_pend = 0; load_val = '0;
        rst_n = 1'b0; cpu_start = 1'b0; cpu_stop = 1'b0;
        redirect = 1'b0; stall = 1'b0; pc_r = 30'h10; exp_pc = 30'h10;

        // Reset values
        #2;
        chk_reset_vals("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // IDLE issues nothing
        iss0 = nissue;
        repeat (3) tick();
        chk("idle_noiss", 32'(nissue - iss0), 32'd0);

        // Straight fetch from 0x10
        cpu_start = 1'b1;
        settle();
        chk("start_re", 32'(imem_re), 32'd0);
        tick();
        cpu_start = 1'b0;
        settle();
        chk("first_re", 32'(imem_re), 32'd1);
        chk("first_adr", 32'(imem_adr), 32'h10);
        tick();
        tick();
        settle();
        chk("lat_early", 32'(inst_vld_id), 32'd0);
        tick();
        settle();
        chk("lat_vld", 32'(inst_vld_id), 32'd1);
        chk("lat_pc", 32'(pc_id), 32'h10);
        chk("lat_inst", inst_id, mem_word(30'h10));
        run_until(5, 40, "straight_pops");

        // Backpressure: credit caps outstanding at BUF_DEPTH
        stall = 1'b1;
        max_out = 0;
        repeat (5) tick();
        settle();
        chk("stall_adv", 32'(fetch_adv), 32'd0);
        chk("stall_vld", 32'(inst_vld_id), 32'd1);
        chk("stall_maxout", 32'(max_out), 32'(BUF_DEPTH));
        stall = 1'b0;
        run_until(12, 60, "stall_release_pops");

        // HALT with two reads outstanding
        n = 0;
        while ((nissue - npop) != 2 && n < 20) begin
            tick();
            n++;
        end
        out_now = nissue - npop;
        chk("halt_two_out", 32'(out_now), 32'd2);
        cpu_stop = 1'b1;
        settle();
        chk("halt_re", 32'(imem_re), 32'd0);
        tick();
        cpu_stop = 1'b0;
        iss0 = nissue;
        n = 0;
        settle();
        while (if_busy && n < 20) begin
            tick();
            n++;
            settle();
        end
        chk("halt_busy", 32'(if_busy), 32'd0);
        chk("halt_noiss", 32'(nissue - iss0), 32'd0);
        chk("halt_drained", 32'(exp_pc), 32'(pc_r));
        chk("halt_vld", 32'(inst_vld_id), 32'd0);
        chk("halt_inst", inst_id, NOP);

        // Restart resumes at the held pc
        cpu_start = 1'b1;
        tick();
        cpu_start = 1'b0;
        base = npop;
        run_until(base + 3, 30, "resume_pops");

        // Restart at 0x20, redirect to 0x40 while 0x20 is in flight
        exp_pc    = 30'h40;
        cpu_start = 1'b1;
        load_val  = 30'h20;
        load_pend = 1'b1;
        tick();
        cpu_start = 1'b0;
        settle();
        chk("redir_iss_re", 32'(imem_re), 32'd1);
        chk("redir_iss_adr", 32'(imem_adr), 32'h20);
        tick();
        redirect  = 1'b1;
        load_val  = 30'h40;
        load_pend = 1'b1;
        settle();
        chk("redir_re", 32'(imem_re), 32'd0);
        chk("redir_vld", 32'(inst_vld_id), 32'd0);
        tick();
        redirect = 1'b0;
        settle();
        chk("redir_next_adr", 32'(imem_adr), 32'h40);
        base = npop;
        run_until(base + 3, 30, "redir_pops");

        // Redirect coinciding with stall and a landing read
        stall = 1'b1;
        found = 1'b0;
        n = 0;
        while (!found && n < 10) begin
            settle();
            if (hist1 && inst_vld_id) found = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        chk("rsp_found", 32'(found), 32'd1);
        redirect  = 1'b1;
        load_val  = 30'h60;
        load_pend = 1'b1;
        #1;
        chk("rsp_same_vld", 32'(inst_vld_id), 32'd0);
        tick();
        redirect = 1'b0;
        settle();
        chk("rsp_vld", 32'(inst_vld_id), 32'd0);
        chk("rsp_inst", inst_id, NOP);
        chk("rsp_busy", 32'(if_busy), 32'd0);
        exp_pc = 30'h60;
        stall  = 1'b0;
        base = npop;
        run_until(base + 2, 30, "rsp_pops");

        // Reset while the buffer is full
        stall = 1'b1;
        repeat (6) tick();
        settle();
        chk("full_vld", 32'(inst_vld_id), 32'd1);
        chk("full_busy", 32'(if_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        tick();
        tick();
        rst_n = 1'b1;
        stall = 1'b0;
        iss0  = nissue;
        repeat (4) tick();
        chk("post_rst_noiss", 32'(nissue - iss0), 32'd0);
        settle();
        chk("post_rst_vld", 32'(inst_vld_id), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
